// File: rtl/vga_sync_gen.sv
// VGA horizontal/vertical timing generator. Advances one pixel per pixel_en strobe and
// registers sync, visible-area, coordinate and line/frame start outputs together.
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned SYNC_POL  = 0,
  parameter int unsigned CW        = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pixel_en,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HSyncStart = H_VISIBLE + H_FRONT;
  localparam int unsigned HSyncEnd   = H_VISIBLE + H_FRONT + H_SYNC;
  localparam int unsigned VSyncStart = V_VISIBLE + V_FRONT;
  localparam int unsigned VSyncEnd   = V_VISIBLE + V_FRONT + V_SYNC;

  localparam logic [CW-1:0] HLast  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VLast  = CW'(V_TOTAL - 1);
  localparam logic          SyncOn = (SYNC_POL != 0);

  // Both totals must fit in CW bits, otherwise the counters cannot reach their last value.
  if ((((H_TOTAL - 1) >> CW) != 0) || (((V_TOTAL - 1) >> CW) != 0)) begin : g_bad_cfg
    $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed 2**CW");
  end

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          h_wrap, v_wrap;

  always_comb begin
    h_wrap = (h_q == HLast);
    v_wrap = (v_q == VLast);
    h_d    = h_q;
    v_d    = v_q;
    if (pixel_en) begin
      h_d = h_wrap ? '0 : h_q + CW'(1);
      if (h_wrap) begin
        v_d = v_wrap ? '0 : v_q + CW'(1);
      end
    end
  end

  // Outputs are decoded from the next counter values so they land on the same edge.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pixel_en) begin
      x_d           = h_d;
      y_d           = v_d;
      video_on_d    = (32'(h_d) < H_VISIBLE) && (32'(v_d) < V_VISIBLE);
      hsync_d       = ((32'(h_d) >= HSyncStart) && (32'(h_d) < HSyncEnd)) ? SyncOn : ~SyncOn;
      vsync_d       = ((32'(v_d) >= VSyncStart) && (32'(v_d) < VSyncEnd)) ? SyncOn : ~SyncOn;
      line_start_d  = (h_d == '0);
      frame_start_d = (h_d == '0) && (v_d == '0);
    end
  end

  // Counters park on their last value so the first strobe after reset lands on (0,0).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h_q           <= HLast;
      v_q           <= VLast;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~SyncOn;
      vsync_q       <= ~SyncOn;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
VGA horizontal/vertical timing generator, directly downstream of the clock divider. Runs on the single system clock and advances one pixel per cycle in which pixel_en is high. pixel_en is the divider's output, delivered as a one-cycle strobe. Produces hsync/vsync, the visible-area flag, pixel coordinates and line/frame start pulses for the pixel-colour stage.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
CW, 10, width of x/y and internal counters; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
pixel_en  in  1  pixel strobe from the divider; counters advance only when high
hsync  out  1  horizontal sync, polarity per SYNC_POL
vsync  out  1  vertical sync, polarity per SYNC_POL
video_on  out  1  high when (x,y) lies inside the visible area
x  out  CW  current pixel column
y  out  CW  current line
line_start  out  1  one-cycle pulse when x becomes 0
frame_start  out  1  one-cycle pulse when (x,y) becomes (0,0)

Behaviour:
- Derived values: H_TOTAL = sum of the four H_ parameters (800 by default); V_TOTAL = sum of the four V_ parameters (525 by default).
- Reset (reset low, asynchronous):
  - internal h counter = H_TOTAL-1, v counter = V_TOTAL-1.
  - x=0, y=0, video_on=0, line_start=0, frame_start=0.
  - hsync = vsync = !SYNC_POL (inactive).
- After reset release, the first pixel_en wraps both counters to (0,0).
- Counter update on each pixel_en cycle:
  - h = (h==H_TOTAL-1) ? 0 : h+1.
  - When h wraps: v = (v==V_TOTAL-1) ? 0 : v+1. Otherwise v holds.
- Cycles with pixel_en low:
  - all counters and registered outputs hold.
  - line_start and frame_start are 0.
- All outputs are registered and update on the same edge as the counters, so every output is consistent with the new (h,v). There is zero extra latency between x/y and the sync/flag outputs.
- x = h, y = v, always, including in blanking.
- video_on = (h < H_VISIBLE) && (v < V_VISIBLE).
- hsync is active when H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC.
- vsync is active when V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC. vsync depends on v only, not on h.
- line_start = 1 for exactly the one cycle following an edge at which h became 0. frame_start additionally requires v = 0.
- pixel_en high on consecutive cycles is legal: one pixel per cycle, no skipped states.
- Reset asserted mid-frame returns to the reset state immediately. Reset has priority over pixel_en.
- Counter comparisons are unsigned CW-bit. The parameter set must satisfy H_TOTAL, V_TOTAL <= 2^CW. Violating this is a configuration error, flagged by an elaboration-time assertion.

Test Plan:
- Reset, release, then one pixel_en -> x=0, y=0, video_on=1, line_start=1, frame_start=1. Before that pixel_en: hsync=vsync=1, video_on=0.
- Defaults, pixel_en every 4th clock, full line -> hsync low exactly for x=656..751 (96 strobes); video_on low from x=640 onward; line_start period = 800 strobes.
- Defaults, full frame -> vsync low exactly on y=490..491 (1600 strobes); frame_start period = 420000 strobes; y wraps from 524 to 0 together with x wrapping from 799 to 0.
- Small config (H 4/1/2/1, V 3/1/1/1, SYNC_POL=1), pixel_en held high -> H_TOTAL=8, V_TOTAL=6; hsync high at x=5..6; vsync high at y=4; frame_start every 48 cycles.
- pixel_en held low for 20 cycles mid-line at x=300 -> x, y, hsync, vsync and video_on unchanged; no pulses.
- Reset asserted at x=700, y=200 asynchronously (mid-cycle) -> outputs return to reset values before the next clock edge. After release, the first pixel_en gives (0,0) with frame_start=1.
